// File: rtl/par_circular_buffer_pkg.sv
// Shared definitions for the parallel circular buffer: wrapped pointer add,
// occupancy-width derivation and parameter legality check.
package par_circular_buffer_pkg;

  // Minimum storage depth for which the pointer width is non-zero.
  localparam int unsigned PAR_BUF_MIN_DEPTH = 32'd2;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int unsigned par_buf_cnt_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  // (ptr + off) mod depth using a single compare-subtract.
  // Valid because ptr < depth and off <= depth, so the sum is below 2*depth.
  function automatic int unsigned par_buf_wrap_add(input int unsigned ptr,
                                                   input int unsigned off,
                                                   input int unsigned depth);
    int unsigned sum;
    sum = ptr + off;
    if (sum >= depth) begin
      sum = sum - depth;
    end else begin
      sum = sum;
    end
    return sum;
  endfunction

  // Window/stride/push sizes must fit in storage, and a pop may not retire
  // more words than the window shows.
  function automatic bit par_buf_params_ok(input int unsigned depth,
                                           input int unsigned par_write,
                                           input int unsigned par_read,
                                           input int unsigned read_stride);
    return (depth >= PAR_BUF_MIN_DEPTH) &&
           (par_write >= 32'd1) && (par_write <= depth) &&
           (par_read >= 32'd1) && (par_read <= depth) &&
           (read_stride >= 32'd1) && (read_stride <= par_read);
  endfunction

endpackage

// File: rtl/par_circular_buffer_ptr_wrap.sv
// Pointer plus offset, wrapped into 0..DEPTH-1. Used for every write lane,
// every read-window lane and for both pointer advances.
module par_buf_ptr_wrap
  import par_circular_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned OFF_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic [ADDR_WIDTH-1:0] ptr_i,
  input  logic [OFF_WIDTH-1:0]  off_i,
  output logic [ADDR_WIDTH-1:0] idx_o
);

  // Wrapped index from the shared modulo-add helper.
  always_comb begin
    idx_o = '0;
    idx_o = ADDR_WIDTH'(par_buf_wrap_add(32'(ptr_i), 32'(off_i), DEPTH));
  end

endmodule

// File: rtl/par_circular_buffer.sv
// Circular FIFO with PAR_WRITE-word pushes and a PAR_READ-word sliding read
// window that advances by READ_STRIDE words per pop.
// Optional feature: define PAR_BUF_FLUSH_EN to add a synchronous flush input.
module par_circular_buffer
  import par_circular_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PAR_WRITE   = 1,
  parameter int unsigned PAR_READ    = 1,
  parameter int unsigned READ_STRIDE = 1,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH   = par_buf_cnt_width(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef PAR_BUF_FLUSH_EN
  input  logic                           flush,
`endif
  input  logic                           wen,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  output logic                           wready,
  input  logic                           ren,
  output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
  output logic                           rvalid,
  output logic [CNT_WIDTH-1:0]           count,
  output logic                           full,
  output logic                           empty
);

  if (!par_buf_params_ok(DEPTH, PAR_WRITE, PAR_READ, READ_STRIDE)) begin : g_bad_params
    $error("par_circular_buffer: illegal DEPTH/PAR_WRITE/PAR_READ/READ_STRIDE");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [ADDR_WIDTH-1:0] wr_idx_s [PAR_WRITE];
  logic [ADDR_WIDTH-1:0] rd_idx_s [PAR_READ];
  logic [ADDR_WIDTH-1:0] wptr_adv_s;
  logic [ADDR_WIDTH-1:0] rptr_adv_s;
  logic                  flush_s;
  logic                  push_s;
  logic                  pop_s;

`ifdef PAR_BUF_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake flags depend on occupancy only: no same-cycle bypass.
  assign wready = (count_q <= CNT_WIDTH'(DEPTH - PAR_WRITE));
  assign rvalid = (count_q >= CNT_WIDTH'(PAR_READ));
  assign full   = (count_q == CNT_WIDTH'(DEPTH));
  assign empty  = (count_q == CNT_WIDTH'(0));
  assign count  = count_q;

  // Flush wins over both push and pop.
  assign push_s = wen & wready & ~flush_s;
  assign pop_s  = ren & rvalid & ~flush_s;

  for (genvar k = 0; k < PAR_WRITE; k++) begin : g_wr_lane
    par_buf_ptr_wrap #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .OFF_WIDTH(CNT_WIDTH)) u_wr (
      .ptr_i (wptr_q),
      .off_i (CNT_WIDTH'(k)),
      .idx_o (wr_idx_s[k])
    );
  end

  for (genvar i = 0; i < PAR_READ; i++) begin : g_rd_lane
    par_buf_ptr_wrap #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .OFF_WIDTH(CNT_WIDTH)) u_rd (
      .ptr_i (rptr_q),
      .off_i (CNT_WIDTH'(i)),
      .idx_o (rd_idx_s[i])
    );
  end

  par_buf_ptr_wrap #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .OFF_WIDTH(CNT_WIDTH)) u_wptr_adv (
    .ptr_i (wptr_q),
    .off_i (CNT_WIDTH'(PAR_WRITE)),
    .idx_o (wptr_adv_s)
  );

  par_buf_ptr_wrap #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .OFF_WIDTH(CNT_WIDTH)) u_rptr_adv (
    .ptr_i (rptr_q),
    .off_i (CNT_WIDTH'(READ_STRIDE)),
    .idx_o (rptr_adv_s)
  );

  // Next pointers and occupancy; flush clears everything.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_s) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        wptr_d  = wptr_adv_s;
        count_d = count_d + CNT_WIDTH'(PAR_WRITE);
      end else begin
        wptr_d  = wptr_q;
      end
      if (pop_s) begin
        rptr_d  = rptr_adv_s;
        count_d = count_d - CNT_WIDTH'(READ_STRIDE);
      end else begin
        rptr_d  = rptr_q;
      end
    end
  end

  // Next memory image: each push lane writes its wrapped slot.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      for (int k = 0; k < PAR_WRITE; k++) begin
        mem_d[wr_idx_s[k]] = din[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Read window; zeroed whenever fewer than PAR_READ words are held so stale
  // storage is never exposed.
  always_comb begin
    dout = '0;
    if (rvalid) begin
      for (int i = 0; i < PAR_READ; i++) begin
        dout[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_idx_s[i]];
      end
    end else begin
      dout = '0;
    end
  end

  // Pointer and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_par_circular_buffer.sv
// Self-checking bench for par_circular_buffer (DEPTH=6, PAR_WRITE=2,
// PAR_READ=3, READ_STRIDE=1). A word queue models the buffer contents.
// Flush scenarios are compiled in when PAR_BUF_FLUSH_EN is defined.
module tb_par_circular_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 6;
  localparam int PW    = 2;
  localparam int PR    = 3;
  localparam int RS    = 1;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wen, ren, flush;
  logic [PW*DW-1:0]  din;
  logic              wready, rvalid, full, empty;
  logic [PR*DW-1:0]  dout;
  logic [CW-1:0]     count;

  int  n_vec = 0;
  int  n_err = 0;
  int  q[$];
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  par_circular_buffer #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .PAR_WRITE (PW),
    .PAR_READ (PR), .READ_STRIDE (RS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef PAR_BUF_FLUSH_EN
    .flush  (flush),
`endif
    .wen    (wen),
    .din    (din),
    .wready (wready),
    .ren    (ren),
    .dout   (dout),
    .rvalid (rvalid),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived purely from the queue contents.
  task automatic check_model(input string tag);
    logic [PR*DW-1:0] win;
    win = '0;
    if (q.size() >= PR) begin
      for (int i = 0; i < PR; i++) win[i*DW +: DW] = q[i][DW-1:0];
    end
    chk({tag, ".count"},  64'(count),  64'(q.size()));
    chk({tag, ".rvalid"}, 64'(rvalid), 64'(q.size() >= PR));
    chk({tag, ".wready"}, 64'(wready), 64'(q.size() <= DEPTH - PW));
    chk({tag, ".full"},   64'(full),   64'(q.size() == DEPTH));
    chk({tag, ".empty"},  64'(empty),  64'(q.size() == 0));
    chk({tag, ".dout"},   64'(dout),   64'(win));
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c);
    int e[3];
    e = '{a, b, c};
    for (int i = 0; i < PR; i++)
      chk($sformatf("%s.w%0d", tag, i), 64'(dout[i*DW +: DW]), 64'(e[i]));
  endtask

  // Compare process: every falling edge, DUT against the model.
  always @(negedge clk) begin
    if (chk_en) check_model("cyc");
  end

  // One clock: apply inputs, update the model at the edge from pre-edge state.
  task automatic step(input bit w, input bit r, input bit f, input int d0, input int d1,
                      output bit pushed, output bit popped);
    int sz;
    wen = w; ren = r; flush = f;
    din = {d1[DW-1:0], d0[DW-1:0]};
    @(posedge clk);
    sz = q.size();
    pushed = w && (sz <= DEPTH - PW) && !f;
    popped = r && (sz >= PR) && !f;
    if (f) begin
      q.delete();
    end else begin
      if (popped) repeat (RS) void'(q.pop_front());
      if (pushed) begin
        q.push_back(d0 & 16'hFFFF);
        q.push_back(d1 & 16'hFFFF);
      end
    end
    #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    #1;
    check_model("rst");
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit pu, po;
    int v, n;
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0; flush = 1'b0; din = '0;

    // 1: reset values, literal expectations
    #2;
    chk("reset.count",  64'(count),  64'd0);
    chk("reset.empty",  64'(empty),  64'd1);
    chk("reset.rvalid", 64'(rvalid), 64'd0);
    chk("reset.dout",   64'(dout),   64'd0);
    chk("reset.wready", 64'(wready), 64'd1);
    chk("reset.full",   64'(full),   64'd0);
    #5; rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 2: window formation
    step(1'b1, 1'b0, 1'b0, 1, 2, pu, po);
    chk("win.rvalid_early", 64'(rvalid), 64'd0);
    step(1'b1, 1'b0, 1'b0, 3, 4, pu, po);
    chk("win.count", 64'(count), 64'd4);
    chk("win.rvalid", 64'(rvalid), 64'd1);
    chk_win("win1", 1, 2, 3);
    step(1'b0, 1'b1, 1'b0, 0, 0, pu, po);
    chk("win.count_pop", 64'(count), 64'd3);
    chk_win("win2", 2, 3, 4);

    // 1b: asynchronous reset mid-stream at count=4
    do_reset();
    step(1'b1, 1'b0, 1'b0, 11, 12, pu, po);
    step(1'b1, 1'b0, 1'b0, 13, 14, pu, po);
    chk("mid.count_pre", 64'(count), 64'd4);
    #1;
    rst_n = 1'b0; q.delete();
    #1;
    chk("mid.count",  64'(count),  64'd0);
    chk("mid.empty",  64'(empty),  64'd1);
    chk("mid.rvalid", 64'(rvalid), 64'd0);
    chk("mid.dout",   64'(dout),   64'd0);
    chk("mid.wready", 64'(wready), 64'd1);
    #1; rst_n = 1'b1;

    // 3: fill to full, then an ignored push
    step(1'b1, 1'b0, 1'b0, 1, 2, pu, po);
    step(1'b1, 1'b0, 1'b0, 3, 4, pu, po);
    step(1'b1, 1'b0, 1'b0, 5, 6, pu, po);
    chk("fill.full",   64'(full),   64'd1);
    chk("fill.wready", 64'(wready), 64'd0);
    step(1'b1, 1'b0, 1'b0, 9, 9, pu, po);
    chk("fill.ignored", 64'(count), 64'd6);
    chk_win("fill", 1, 2, 3);

    // 5: push and pop together at full: only the pop lands
    step(1'b1, 1'b1, 1'b0, 9, 9, pu, po);
    chk("simfull.count", 64'(count), 64'd5);
    chk_win("simfull", 2, 3, 4);

`ifdef PAR_BUF_FLUSH_EN
    // 6: flush beats push and pop; next data lands at the head
    step(1'b1, 1'b1, 1'b1, 9, 9, pu, po);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.empty", 64'(empty), 64'd1);
    step(1'b1, 1'b0, 1'b0, 7, 8, pu, po);
    step(1'b1, 1'b0, 1'b0, 9, 10, pu, po);
    chk_win("flush", 7, 8, 9);
`endif

    // 4: steady push/pop with wrap-around, window must be {n,n+1,n+2}
    do_reset();
    v = 1; n = 1;
    for (int c = 0; c < 20; c++) begin
      if (q.size() >= PR) chk_win($sformatf("wrap%0d", c), n, n + 1, n + 2);
      step(1'b1, 1'b1, 1'b0, v, v + 1, pu, po);
      if (pu) v += 2;
      if (po) n++;
    end
    chk("wrap.pops", 64'(n > 12), 64'd1);

    // Randomized traffic checked against the queue model every cycle
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 60,
`ifdef PAR_BUF_FLUSH_EN
             $urandom_range(0, 99) < 2,
`else
             1'b0,
`endif
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), pu, po);
      end
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
